matmul_apb_ctrl: RTL and testbench
==================================

Name: matmul_apb_ctrl

Overview:
- Parametrised APB completer for the matmul accelerator; the next generation of the matmul APB front-end.
- Decodes APB accesses into a control/status register space and a forwarded operand/result memory window toward the matmul core.
- Adds per-element write strobes, variable-latency memory reads with timeout, busy lockout, a sticky done flag and registered error responses.
- Sits between the testbench/SoC APB requester and the matmul core plus its operand memories.

Parameters:
- DATA_WIDTH, 8, element width in bits.
- MAX_DIM, 4, elements per bus word; also the strobe width.
- BUS_WIDTH, DATA_WIDTH*MAX_DIM, APB data width.
- ADDR_WIDTH, 16, APB address width.
- MODE_WIDTH, 3, width of the CTRL mode field.
- TIMEOUT, 16, maximum cycles to wait for mem_rvalid_i before an error response.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable.
- pwrite_i  in  1  1 = write.
- pstrb_i  in  MAX_DIM  per-element write strobe.
- pwdata_i  in  BUS_WIDTH  write data.
- paddr_i  in  ADDR_WIDTH  address.
- pready_o  out  1  transfer complete.
- pslverr_o  out  1  error, valid only with pready_o.
- prdata_o  out  BUS_WIDTH  read data, valid only with pready_o.
- busy_o  out  1  registered copy of core_busy_i.
- core_busy_i  in  1  matmul core is running.
- start_o  out  1  one-cycle start pulse to the core.
- mode_o  out  MODE_WIDTH  CTRL mode field.
- mem_req_o  out  1  one-cycle memory request.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_WIDTH-1  memory word address.
- mem_wdata_o  out  BUS_WIDTH  memory write data.
- mem_be_o  out  MAX_DIM  element enables (equal to the captured pstrb_i).
- mem_rdata_i  in  BUS_WIDTH  memory read data.
- mem_rvalid_i  in  1  read data valid.

Behaviour:
- Reset (asynchronous, rst_i=1): every output is 0; CTRL.mode=0; done=0; FSM=IDLE. Reset mid-transfer abandons the transfer with no pready_o; the requester must restart it.
- All outputs are registered.
- Address decode:
  - paddr_i[ADDR_WIDTH-1]=1: memory window; mem_addr_o=paddr_i[ADDR_WIDTH-2:0].
  - paddr_i[ADDR_WIDTH-1]=0: register space. Index 0 = CTRL (R/W). Index 1 = STATUS (RO). Any other index is unmapped.
- CTRL layout: bit0 = start (write-1 pulse, reads 0); bits[MODE_WIDTH:1] = mode. A write takes effect only when pstrb_i[0]=1.
- STATUS layout: bit0 = busy; bit1 = done.
  - done is set on a core_busy_i 1->0 edge and cleared by a STATUS read.
  - If set and clear coincide, set wins.
  - The read returns the pre-clear value.
- FSM states: IDLE, ACCESS, RD_WAIT, RESP.
  - IDLE: on psel_i=1 and penable_i=0, capture paddr_i, pwrite_i, pwdata_i, pstrb_i and core_busy_i; go to ACCESS.
  - ACCESS, register or error path: compute the result, go to RESP.
  - ACCESS, memory path, no error: assert mem_req_o for 1 cycle. mem_we_o=pwrite_i, mem_be_o = captured strobe (0 for reads). Writes go to RESP; reads go to RD_WAIT.
  - RD_WAIT: wait for mem_rvalid_i, then register mem_rdata_i and go to RESP. Cycle counter: if TIMEOUT cycles pass without mem_rvalid_i, go to RESP with pslverr_o=1 and prdata_o=0. A late mem_rvalid_i is ignored.
  - RESP: pready_o=1 for exactly one cycle, together with pslverr_o and prdata_o; then IDLE.
  - Any state: psel_i dropping before RESP is a protocol violation; return to IDLE with no pready_o and no further mem_req_o.
- Latency from the SETUP cycle to pready_o:
  - Register or memory write: 2 cycles.
  - Memory read: 3 cycles plus the memory delay (rvalid in the cycle after mem_req_o gives 3).
- Error conditions (pslverr_o=1; no side effects; prdata_o=0):
  - unmapped register;
  - write to STATUS;
  - memory access with captured busy=1;
  - CTRL write with start=1 and captured busy=1 (mode is not updated);
  - read timeout.
- start_o: pulses 1 cycle, in the RESP cycle, on an error-free CTRL write with bit0=1 and strobe 0 set.
- busy_o follows core_busy_i with 1-cycle delay.
- Back-to-back transfers are supported: the SETUP cycle may occur in the cycle after RESP.

Test Plan:
- Write CTRL pwdata=0x0000000B, pstrb=0001, core idle -> pready 2 cycles after SETUP, pslverr=0, start_o 1-cycle pulse, mode_o=5; CTRL readback = 0x0000000A.
- Memory write paddr=0x8004, pwdata=0xA1B2C3D4, pstrb=0101 -> mem_req_o=1, mem_we_o=1, mem_addr_o=0x0004, mem_be_o=0101; pready next cycle.
- Memory read paddr=0x8010 with mem_rvalid_i 4 cycles after mem_req_o, data 0x11223344 -> prdata_o=0x11223344, pslverr=0. Repeat with no rvalid -> pslverr=1 after TIMEOUT=16 cycles, prdata=0.
- core_busy_i=1 with a memory write and a CTRL start write -> both pslverr=1; no mem_req_o, no start_o, mode unchanged.
- core_busy_i 1->0, then STATUS read -> prdata=0x2; second STATUS read -> 0x0. Falling edge coinciding with the read -> done stays 1.
- Read index 5 -> pslverr=1. Assert rst_i in RD_WAIT -> all outputs 0 immediately, no pready_o. Next transfer completes normally.

Source files
------------

// File: rtl/matmul_apb_ctrl_if.sv
// APB bus bundle between the requester and the matmul control front-end.
// Signal names keep the completer-side direction suffixes.
interface matmul_apb_ctrl_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int BUS_WIDTH  = 32,
   parameter int MAX_DIM    = 4
) ();
   logic                  psel_i;
   logic                  penable_i;
   logic                  pwrite_i;
   logic [MAX_DIM-1:0]    pstrb_i;
   logic [BUS_WIDTH-1:0]  pwdata_i;
   logic [ADDR_WIDTH-1:0] paddr_i;
   logic                  pready_o;
   logic                  pslverr_o;
   logic [BUS_WIDTH-1:0]  prdata_o;

   modport master (
      output psel_i, penable_i, pwrite_i, pstrb_i, pwdata_i, paddr_i,
      input  pready_o, pslverr_o, prdata_o
   );

   modport slave (
      input  psel_i, penable_i, pwrite_i, pstrb_i, pwdata_i, paddr_i,
      output pready_o, pslverr_o, prdata_o
   );
endinterface

// File: rtl/matmul_apb_ctrl.sv
// APB completer for the matmul accelerator: CTRL/STATUS registers plus a
// forwarded memory window with variable-latency reads and a read timeout.
module matmul_apb_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_DIM    = 4,
   parameter int BUS_WIDTH  = DATA_WIDTH * MAX_DIM,
   parameter int ADDR_WIDTH = 16,
   parameter int MODE_WIDTH = 3,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   matmul_apb_ctrl_if.slave      apb,
   input  logic                  core_busy_i,
   output logic                  busy_o,
   output logic                  start_o,
   output logic [MODE_WIDTH-1:0] mode_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-2:0] mem_addr_o,
   output logic [BUS_WIDTH-1:0]  mem_wdata_o,
   output logic [MAX_DIM-1:0]    mem_be_o,
   input  logic [BUS_WIDTH-1:0]  mem_rdata_i,
   input  logic                  mem_rvalid_i
);
   localparam int IDX_W = ADDR_WIDTH - 1;
   localparam int TMR_W = $clog2(TIMEOUT) + 1;
   localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(0);
   localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(1);

   typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT, RESP} state_e;

   state_e                state_q, state_d;
   logic                  is_mem_q, is_mem_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  write_q, write_d;
   logic [MODE_WIDTH:0]   cwdata_q, cwdata_d;
   logic                  strb0_q, strb0_d;
   logic                  cbusy_q, cbusy_d;
   logic [TMR_W-1:0]      tmr_q, tmr_d;
   logic                  done_q, done_d;
   logic                  done_clr;
   logic [MODE_WIDTH-1:0] mode_q, mode_d;
   logic                  busy_q, busy_d;
   logic                  start_q, start_d;
   logic                  pready_q, pready_d;
   logic                  pslverr_q, pslverr_d;
   logic [BUS_WIDTH-1:0]  prdata_q, prdata_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [IDX_W-1:0]      mem_addr_q, mem_addr_d;
   logic [BUS_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
   logic [MAX_DIM-1:0]    mem_be_q, mem_be_d;

   always_comb begin
      state_d     = state_q;
      is_mem_d    = is_mem_q;
      idx_d       = idx_q;
      write_d     = write_q;
      cwdata_d    = cwdata_q;
      strb0_d     = strb0_q;
      cbusy_d     = cbusy_q;
      tmr_d       = tmr_q;
      mode_d      = mode_q;
      busy_d      = core_busy_i;
      done_clr    = 1'b0;
      start_d     = 1'b0;
      pready_d    = 1'b0;
      pslverr_d   = 1'b0;
      prdata_d    = '0;
      mem_req_d   = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      mem_be_d    = '0;

      unique case (state_q)
         IDLE: begin
            if (apb.psel_i && !apb.penable_i) begin
               is_mem_d = apb.paddr_i[ADDR_WIDTH-1];
               idx_d    = apb.paddr_i[ADDR_WIDTH-2:0];
               write_d  = apb.pwrite_i;
               cwdata_d = apb.pwdata_i[MODE_WIDTH:0];
               strb0_d  = apb.pstrb_i[0];
               cbusy_d  = core_busy_i;
               state_d  = ACCESS;
               // Launched from SETUP so the request is already on the pins during ACCESS.
               if (apb.paddr_i[ADDR_WIDTH-1] && !core_busy_i) begin
                  mem_req_d   = 1'b1;
                  mem_we_d    = apb.pwrite_i;
                  mem_addr_d  = apb.paddr_i[ADDR_WIDTH-2:0];
                  mem_wdata_d = apb.pwrite_i ? apb.pwdata_i : '0;
                  mem_be_d    = apb.pwrite_i ? apb.pstrb_i : '0;
               end
            end
         end
         ACCESS: begin
            if (!apb.psel_i) begin
               state_d = IDLE;
            end else if (is_mem_q && !cbusy_q && !write_q) begin
               state_d = RD_WAIT;
               tmr_d   = '0;
            end else begin
               state_d  = RESP;
               pready_d = 1'b1;
               if (is_mem_q) begin
                  pslverr_d = cbusy_q;
               end else if (idx_q == IDX_CTRL) begin
                  if (!write_q) begin
                     prdata_d = BUS_WIDTH'({mode_q, 1'b0});
                  end else if (strb0_q) begin
                     if (cwdata_q[0] && cbusy_q) begin
                        pslverr_d = 1'b1;
                     end else begin
                        mode_d  = cwdata_q[MODE_WIDTH:1];
                        start_d = cwdata_q[0];
                     end
                  end
               end else if (idx_q == IDX_STATUS && !write_q) begin
                  prdata_d = BUS_WIDTH'({done_q, cbusy_q});
                  done_clr = 1'b1;
               end else begin
                  pslverr_d = 1'b1;
               end
            end
         end
         RD_WAIT: begin
            if (!apb.psel_i) begin
               state_d = IDLE;
            end else if (mem_rvalid_i) begin
               state_d  = RESP;
               pready_d = 1'b1;
               prdata_d = mem_rdata_i;
            end else if (tmr_q == TMR_LAST) begin
               state_d   = RESP;
               pready_d  = 1'b1;
               pslverr_d = 1'b1;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // A busy falling edge in the same cycle as a STATUS read keeps done set.
      done_d = (busy_q & ~core_busy_i) | (done_q & ~done_clr);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         tmr_q       <= '0;
         done_q      <= 1'b0;
         mode_q      <= '0;
         busy_q      <= 1'b0;
         start_q     <= 1'b0;
         pready_q    <= 1'b0;
         pslverr_q   <= 1'b0;
         prdata_q    <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         done_q      <= done_d;
         mode_q      <= mode_d;
         busy_q      <= busy_d;
         start_q     <= start_d;
         pready_q    <= pready_d;
         pslverr_q   <= pslverr_d;
         prdata_q    <= prdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
      end
   end

   // Captured request fields are only consumed after IDLE has loaded them.
   always_ff @(posedge clk_i) begin
      is_mem_q <= is_mem_d;
      idx_q    <= idx_d;
      write_q  <= write_d;
      cwdata_q <= cwdata_d;
      strb0_q  <= strb0_d;
      cbusy_q  <= cbusy_d;
   end

   assign apb.pready_o  = pready_q;
   assign apb.pslverr_o = pslverr_q;
   assign apb.prdata_o  = prdata_q;
   assign busy_o        = busy_q;
   assign start_o       = start_q;
   assign mode_o        = mode_q;
   assign mem_req_o     = mem_req_q;
   assign mem_we_o      = mem_we_q;
   assign mem_addr_o    = mem_addr_q;
   assign mem_wdata_o   = mem_wdata_q;
   assign mem_be_o      = mem_be_q;
endmodule

// File: tb/tb_matmul_apb_ctrl.sv
// Scoreboard bench for matmul_apb_ctrl: a transaction-level model predicts each
// APB response and memory request; monitors compare whenever the DUT presents one.
module tb_matmul_apb_ctrl;
   localparam int DW = 8;
   localparam int MD = 4;
   localparam int BW = DW * MD;
   localparam int AW = 16;
   localparam int MW = 3;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          core_busy_i;
   logic          busy_o;
   logic          start_o;
   logic [MW-1:0] mode_o;
   logic          mem_req_o;
   logic          mem_we_o;
   logic [AW-2:0] mem_addr_o;
   logic [BW-1:0] mem_wdata_o;
   logic [MD-1:0] mem_be_o;
   logic [BW-1:0] mem_rdata_i;
   logic          mem_rvalid_i;

   matmul_apb_ctrl_if #(.ADDR_WIDTH(AW), .BUS_WIDTH(BW), .MAX_DIM(MD)) apb_if ();

   matmul_apb_ctrl #(
      .DATA_WIDTH(DW), .MAX_DIM(MD), .BUS_WIDTH(BW),
      .ADDR_WIDTH(AW), .MODE_WIDTH(MW), .TIMEOUT(TO)
   ) dut (
      .clk_i(clk), .rst_i(rst), .apb(apb_if),
      .core_busy_i(core_busy_i), .busy_o(busy_o), .start_o(start_o), .mode_o(mode_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          err;
      logic [BW-1:0] rdata;
      logic          start;
      logic [MW-1:0] mode;
      int            lat;
      int            setup_cyc;
   } rsp_t;

   typedef struct {
      logic          we;
      logic [AW-2:0] addr;
      logic [BW-1:0] wdata;
      logic [MD-1:0] be;
   } mreq_t;

   rsp_t          rsp_q[$];
   mreq_t         mreq_q[$];
   int            n_chk  = 0;
   int            n_pass = 0;
   int            cyc    = 0;
   logic [MW-1:0] mode_m;
   logic          done_m;
   logic          cb_m;
   int            rd_delay;
   logic [BW-1:0] rv_data;
   int            rv_cnt;
   logic          prev_cb;

   task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // APB response monitor
   always @(negedge clk) begin : rsp_mon
      rsp_t e;
      if (!rst) begin
         if (apb_if.pready_o) begin
            if (rsp_q.size() == 0) begin
               check("unexpected_pready", 1'b1, 1'b0);
            end else begin
               e = rsp_q.pop_front();
               check("pslverr", apb_if.pslverr_o, e.err);
               check("prdata", apb_if.prdata_o, e.rdata);
               check("latency", cyc - e.setup_cyc, e.lat);
               check("start_o", start_o, e.start);
               check("mode_o", mode_o, e.mode);
               check("busy_o", busy_o, prev_cb);
            end
         end else if (start_o) begin
            check("stray_start", start_o, 1'b0);
         end
      end
      prev_cb = core_busy_i;
   end

   // Memory model: checks each request and answers reads after rd_delay cycles
   always @(negedge clk) begin : mem_mon
      mreq_t m;
      mem_rvalid_i = 1'b0;
      if (rst) begin
         rv_cnt      = 0;
         mem_rdata_i = '0;
      end else begin
         if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
               mem_rvalid_i = 1'b1;
               mem_rdata_i  = rv_data;
            end
         end
         if (mem_req_o) begin
            if (mreq_q.size() == 0) begin
               check("unexpected_mem_req", 1'b1, 1'b0);
            end else begin
               m = mreq_q.pop_front();
               check("mem_we", mem_we_o, m.we);
               check("mem_addr", mem_addr_o, m.addr);
               check("mem_be", mem_be_o, m.be);
               check("mem_wdata", mem_wdata_o, m.wdata);
               if (!m.we && rd_delay > 0) rv_cnt = rd_delay;
            end
         end
      end
   end

   task automatic push_mreq(input logic we, input logic [AW-2:0] addr,
                            input logic [BW-1:0] wdata, input logic [MD-1:0] be);
      mreq_t m;
      m.we = we; m.addr = addr; m.wdata = wdata; m.be = be;
      mreq_q.push_back(m);
   endtask

   // Called at posedge+1; returns at posedge+1 after the response cycle.
   task automatic apb_xfer(input logic [AW-1:0] addr, input logic wr, input logic [BW-1:0] wdata,
                           input logic [MD-1:0] strb, input logic fall = 1'b0);
      rsp_t          e;
      logic [AW-2:0] idx;
      bit            got;
      e.err = 1'b0; e.rdata = '0; e.start = 1'b0; e.lat = 2;
      idx = addr[AW-2:0];
      if (addr[AW-1]) begin
         if (cb_m) begin
            e.err = 1'b1;
         end else begin
            push_mreq(wr, idx, wr ? wdata : '0, wr ? strb : '0);
            if (!wr) begin
               if (rd_delay >= 1 && rd_delay <= TO) begin
                  e.rdata = rv_data;
                  e.lat   = 2 + rd_delay;
               end else begin
                  e.err = 1'b1;
                  e.lat = 2 + TO;
               end
            end
         end
      end else if (idx == 0) begin
         if (!wr) begin
            e.rdata = BW'({mode_m, 1'b0});
         end else if (strb[0]) begin
            if (wdata[0] && cb_m) e.err = 1'b1;
            else begin
               mode_m  = wdata[MW:1];
               e.start = wdata[0];
            end
         end
      end else if (idx == 1 && !wr) begin
         e.rdata = BW'({done_m, cb_m});
         done_m  = fall;
      end else begin
         e.err = 1'b1;
      end
      e.mode = mode_m;

      apb_if.psel_i    = 1'b1;
      apb_if.penable_i = 1'b0;
      apb_if.pwrite_i  = wr;
      apb_if.paddr_i   = addr;
      apb_if.pwdata_i  = wdata;
      apb_if.pstrb_i   = strb;
      e.setup_cyc      = cyc;
      rsp_q.push_back(e);
      @(posedge clk); #1;
      apb_if.penable_i = 1'b1;
      if (fall) begin
         core_busy_i = 1'b0;
         cb_m        = 1'b0;
      end
      got = 0;
      for (int i = 0; i < 3 * TO; i++) begin
         @(negedge clk);
         if (apb_if.pready_o) begin
            got = 1;
            break;
         end
      end
      if (!got) begin
         check("pready_timeout", 1'b0, 1'b1);
         if (rsp_q.size() > 0) void'(rsp_q.pop_front());
      end
      @(posedge clk); #1;
      apb_if.psel_i    = 1'b0;
      apb_if.penable_i = 1'b0;
   endtask

   task automatic set_busy(input logic v);
      if (cb_m && !v) done_m = 1'b1;
      cb_m        = v;
      core_busy_i = v;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_pready"}, apb_if.pready_o, 1'b0);
      check({tag, "_pslverr"}, apb_if.pslverr_o, 1'b0);
      check({tag, "_prdata"}, apb_if.prdata_o, '0);
      check({tag, "_busy"}, busy_o, 1'b0);
      check({tag, "_start"}, start_o, 1'b0);
      check({tag, "_mode"}, mode_o, '0);
      check({tag, "_mem_req"}, mem_req_o, 1'b0);
      check({tag, "_mem_we"}, mem_we_o, 1'b0);
      check({tag, "_mem_addr"}, mem_addr_o, '0);
      check({tag, "_mem_wdata"}, mem_wdata_o, '0);
      check({tag, "_mem_be"}, mem_be_o, '0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

   initial begin : stim
      int            kind;
      logic [AW-1:0] a;
      rst              = 1'b1;
      core_busy_i      = 1'b0;
      apb_if.psel_i    = 1'b0;
      apb_if.penable_i = 1'b0;
      apb_if.pwrite_i  = 1'b0;
      apb_if.paddr_i   = '0;
      apb_if.pwdata_i  = '0;
      apb_if.pstrb_i   = '0;
      rd_delay = 0; rv_data = '0;
      mode_m = '0; done_m = 1'b0; cb_m = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst = 1'b0;
      idle(1);

      // Register and memory basics
      apb_xfer(16'h0000, 1'b1, 32'h0000_000B, 4'b0001);
      apb_xfer(16'h0000, 1'b0, '0, 4'b0000);
      apb_xfer(16'h8004, 1'b1, 32'hA1B2_C3D4, 4'b0101);
      rd_delay = 4; rv_data = 32'h1122_3344;
      apb_xfer(16'h8010, 1'b0, '0, 4'b0000);
      rd_delay = 0;
      apb_xfer(16'h8010, 1'b0, '0, 4'b0000);
      rd_delay = TO; rv_data = $urandom;
      apb_xfer(16'h8123, 1'b0, '0, 4'b0000);
      rd_delay = TO + 3; rv_data = $urandom;
      apb_xfer(16'h8010, 1'b0, '0, 4'b0000);
      idle(6);

      // Busy lockout
      set_busy(1'b1);
      apb_xfer(16'h8004, 1'b1, 32'hDEAD_BEEF, 4'b1111);
      apb_xfer(16'h0000, 1'b1, 32'h0000_0003, 4'b0001);
      apb_xfer(16'h0000, 1'b0, '0, 4'b0000);
      apb_xfer(16'h0000, 1'b1, 32'h0000_0006, 4'b0001);

      // Sticky done
      set_busy(1'b0);
      apb_xfer(16'h0001, 1'b0, '0, 4'b0000);
      apb_xfer(16'h0001, 1'b0, '0, 4'b0000);
      set_busy(1'b1);
      apb_xfer(16'h0001, 1'b0, '0, 4'b0000, 1'b1);
      apb_xfer(16'h0001, 1'b0, '0, 4'b0000);
      apb_xfer(16'h0001, 1'b0, '0, 4'b0000);

      // Error decode, strobe gating, back-to-back
      apb_xfer(16'h0005, 1'b0, '0, 4'b0000);
      apb_xfer(16'h0001, 1'b1, 32'h0000_00FF, 4'b1111);
      apb_xfer(16'h0000, 1'b1, 32'h0000_000F, 4'b1110);
      apb_xfer(16'h0000, 1'b1, 32'h0000_000E, 4'b0001);
      apb_xfer(16'h0000, 1'b0, '0, 4'b0000);

      // Reset while waiting for read data
      set_busy(1'b1);
      set_busy(1'b0);
      rd_delay = 0;
      push_mreq(1'b0, 15'h0010, '0, '0);
      apb_if.psel_i    = 1'b1;
      apb_if.penable_i = 1'b0;
      apb_if.pwrite_i  = 1'b0;
      apb_if.paddr_i   = 16'h8010;
      @(posedge clk); #1;
      apb_if.penable_i = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_outputs_zero("rst_rdwait");
      mode_m = '0; done_m = 1'b0;
      @(posedge clk); #1;
      apb_if.psel_i    = 1'b0;
      apb_if.penable_i = 1'b0;
      rsp_q.delete();
      mreq_q.delete();
      rst = 1'b0;
      idle(1);
      apb_xfer(16'h0001, 1'b0, '0, 4'b0000);
      apb_xfer(16'h0000, 1'b0, '0, 4'b0000);
      rd_delay = 1; rv_data = 32'hCAFE_F00D;
      apb_xfer(16'h8010, 1'b0, '0, 4'b0000);

      // Randomized traffic
      for (int n = 0; n < 80; n++) begin
         kind = $urandom_range(0, 9);
         case (kind)
            0, 1: apb_xfer(16'h0000, 1'b1, $urandom, 4'($urandom_range(0, 15)));
            2:    apb_xfer(16'h0000, 1'b0, '0, 4'b0000);
            3:    apb_xfer(16'h0001, 1'b0, '0, 4'b0000);
            4:    apb_xfer(16'h0001, 1'b1, $urandom, 4'b1111);
            5: begin
               a = AW'($urandom_range(2, 16'h7FFF));
               apb_xfer(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
            end
            6: begin
               a = {1'b1, 15'($urandom)};
               apb_xfer(a, 1'b1, $urandom, 4'($urandom_range(0, 15)));
            end
            7, 8: begin
               a        = {1'b1, 15'($urandom)};
               rd_delay = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, TO);
               rv_data  = $urandom;
               apb_xfer(a, 1'b0, '0, 4'b0000);
            end
            default: set_busy(~cb_m);
         endcase
         if ($urandom_range(0, 2) == 0) idle(1);
      end

      idle(TO + 4);
      check("rsp_queue_drained", rsp_q.size(), 0);
      check("mem_queue_drained", mreq_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
